fifo_stream_reader: RTL and testbench

Receive-side consumer for the asynchronous FIFO. Runs entirely in the `recv_clk` domain. It pops words from the FIFO read port and re-presents them as a valid/ready stream with burst framing (`out_last`), so downstream logic never has to handle the FIFO's one-cycle read latency or the empty flag. A 3-entry output buffer sustains one word per cycle under continuous `out_ready`.

---
 rtl/fifo_stream_reader.sv | 121 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module   : fifo_stream_reader
// Brief    : Pops an async-FIFO read port into a 3-entry skid buffer and
//            re-presents it as a framed valid/ready stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
    parameter int data_bus_length = 8,
    parameter int burst_length    = 4,
    parameter int count_width     = 16
) (
    input  logic                       recv_clk,
    input  logic                       recv_rst,
    input  logic                       enable,
    input  logic                       fifo_empty,
    input  logic [data_bus_length-1:0] recv_data,
    output logic                       read_enable,
    output logic [data_bus_length-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [count_width-1:0]     word_count,
    output logic                       idle
);

    localparam int                BEAT_W    = (burst_length > 1) ? $clog2(burst_length) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(burst_length - 1);
    localparam int                DEPTH     = 3;

    logic [data_bus_length-1:0] mem_q [DEPTH];
    logic [1:0]                 count_q, count_d;
    logic [1:0]                 rd_ptr_q, rd_ptr_d;
    logic [1:0]                 wr_ptr_q, wr_ptr_d;
    logic                       inflight_q;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [count_width-1:0]     word_count_q, word_count_d;

    logic                       w_capture;
    logic                       w_xfer;
    logic                       w_credit;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts the in-flight pop so the capture slot is always free.
    assign w_credit    = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3;
    assign read_enable = !recv_rst && enable && !fifo_empty && w_credit;

    assign w_capture = inflight_q;
    assign out_valid = (count_q != 2'd0);
    assign w_xfer    = out_valid && out_ready;
    assign out_last  = out_valid && (beat_q == LAST_BEAT);
    assign word_count = word_count_q;
    assign idle      = (count_q == 2'd0) && !inflight_q;

    always_comb begin
        out_data = mem_q[0];
        case (rd_ptr_q)
            2'd1:    out_data = mem_q[1];
            2'd2:    out_data = mem_q[2];
            default: out_data = mem_q[0];
        endcase
    end

    always_comb begin
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        beat_d       = beat_q;
        word_count_d = word_count_q;
        if (w_capture) begin
            wr_ptr_d = inc3(wr_ptr_q);
        end
        if (w_xfer) begin
            rd_ptr_d     = inc3(rd_ptr_q);
            word_count_d = word_count_q + 1'b1;
            beat_d       = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
        case ({w_capture, w_xfer})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge recv_clk) begin
        if (recv_rst) begin
            count_q      <= 2'd0;
            rd_ptr_q     <= 2'd0;
            wr_ptr_q     <= 2'd0;
            inflight_q   <= 1'b0;
            beat_q       <= '0;
            word_count_q <= '0;
        end else begin
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            inflight_q   <= read_enable;
            beat_q       <= beat_d;
            word_count_q <= word_count_d;
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            always_ff @(posedge recv_clk) begin
                if (recv_rst) begin
                    mem_q[g] <= '0;
                end else if (w_capture && (wr_ptr_q == 2'(g))) begin
                    mem_q[g] <= recv_data;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ============================================================================
// Module   : tb_fifo_stream_reader
// Brief    : Scoreboard bench for fifo_stream_reader with a behavioural FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_stream_reader;

    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic [15:0] wc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        rdy = 1'b1;
    logic        en1 = 1'b1;
    logic        rdy1 = 1'b1;

    logic        fe0, re0, ov0, ol0, idle0;
    logic [7:0]  rd0 = 8'h00;
    logic [7:0]  od0;
    logic [15:0] wc0;

    logic        fe1, re1, ov1, ol1, idle1;
    logic [7:0]  rd1 = 8'h00;
    logic [7:0]  od1;
    logic [3:0]  wc1;

    logic [7:0]  fm0 [0:127];
    logic [7:0]  fm1 [0:31];
    int          fw0 = 0, fr0 = 0, pops0 = 0;
    int          fw1 = 0, fr1 = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    int          eidx = 0;

    int          nvec = 0, nfail = 0;
    int          cyc = 0;
    int          ntx0 = 0, nval0 = 0, ntx1 = 0;
    int          t_re = -1, t_v = -1, t_first = -1, t_last = -1;

    always #5 clk = ~clk;

    fifo_stream_reader #(.data_bus_length(8), .burst_length(4), .count_width(16)) dut0 (
        .recv_clk(clk), .recv_rst(rst), .enable(en), .fifo_empty(fe0),
        .recv_data(rd0), .read_enable(re0), .out_data(od0), .out_valid(ov0),
        .out_ready(rdy), .out_last(ol0), .word_count(wc0), .idle(idle0)
    );

    fifo_stream_reader #(.data_bus_length(8), .burst_length(1), .count_width(4)) dut1 (
        .recv_clk(clk), .recv_rst(rst), .enable(en1), .fifo_empty(fe1),
        .recv_data(rd1), .read_enable(re1), .out_data(od1), .out_valid(ov1),
        .out_ready(rdy1), .out_last(ol1), .word_count(wc1), .idle(idle1)
    );

    // Behavioural FIFOs: data appears on the cycle after a pop
    assign fe0 = (fw0 == fr0);
    assign fe1 = (fw1 == fr1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re0) begin
            rd0   <= fm0[fr0];
            fr0   <= fr0 + 1;
            pops0 <= pops0 + 1;
        end
        if (re1) begin
            rd1 <= fm1[fr1];
            fr1 <= fr1 + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect0(input logic [7:0] d);
        exp_t e;
        e.d  = d;
        e.l  = (eidx % 4 == 3);
        e.wc = eidx[15:0];
        q0.push_back(e);
        eidx++;
    endtask

    task automatic push0(input logic [7:0] d);
        fm0[fw0] = d;
        fw0++;
        expect0(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain0(input int target, input string name);
        for (int k = 0; k < 60 && !(ntx0 >= target && idle0 && fe0); k++) tick();
        chk(name, (ntx0 >= target && idle0) ? 1 : 0, 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (re0) chk("re_while_empty0", fe0, 0);
            if (re1) chk("re_while_empty1", fe1, 0);
            if (t_re < 0 && re0) t_re = cyc;
            if (t_v < 0 && ov0) t_v = cyc;
            if (ov0) nval0++;
            if (ov0 && rdy) begin
                if (q0.size() == 0) begin
                    chk("unexpected_xfer0", od0, 32'hFFFF_FFFF);
                end else begin
                    e0 = q0.pop_front();
                    chk("data0", od0, e0.d);
                    chk("last0", ol0, e0.l);
                    chk("wcount0", wc0, e0.wc);
                end
                ntx0++;
                if (t_first < 0) t_first = cyc;
                t_last = cyc;
            end
            if (ov1 && rdy1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_xfer1", od1, 32'hFFFF_FFFF);
                end else begin
                    e1 = q1.pop_front();
                    chk("data1", od1, e1.d);
                    chk("last1", ol1, 1);
                end
                ntx1++;
            end
        end
    end

    initial begin
        int p, v, t, rem;
        exp_t e;

        tick();
        tick();
        chk("rst_read_enable", re0, 0);
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_data", od0, 0);
        chk("rst_out_last", ol0, 0);
        chk("rst_word_count", wc0, 0);
        chk("rst_idle", idle0, 1);
        chk("rst_idle1", idle1, 1);
        rst = 1'b0;
        tick();

        // Basic stream, 17..32
        for (int i = 17; i <= 32; i++) push0(8'(i));
        en = 1'b1;
        drain0(16, "basic_timeout");
        chk("basic_latency", t_v - t_re, 2);
        chk("basic_throughput", t_last - t_first, 15);
        chk("basic_word_count", wc0, 16);
        chk("basic_idle", idle0, 1);

        // Backpressure
        rdy = 1'b0;
        p = pops0;
        for (int i = 17; i <= 32; i++) push0(8'(i));
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ov0) chk("bp_hold_data", od0, 17);
        end
        chk("bp_pops", pops0 - p, 3);
        chk("bp_valid", ov0, 1);
        chk("bp_read_enable", re0, 0);
        chk("bp_idle", idle0, 0);
        rdy = 1'b1;
        drain0(32, "bp_timeout");
        chk("bp_word_count", wc0, 32);

        // Single word through an otherwise empty FIFO
        p = pops0;
        v = nval0;
        push0(8'hA5);
        for (int k = 0; k < 8; k++) tick();
        chk("single_pops", pops0 - p, 1);
        chk("single_valid_cycles", nval0 - v, 1);
        chk("single_word_count", wc0, 33);
        chk("single_idle", idle0, 1);

        // Enable gap after the 6th pop
        p = pops0;
        t = ntx0;
        for (int i = 1; i <= 16; i++) push0(8'(i));
        for (int k = 0; k < 30 && (pops0 - p) < 6; k++) tick();
        en = 1'b0;
        chk("gap_sixth_pop", pops0 - p, 6);
        for (int k = 0; k < 8; k++) tick();
        chk("gap_no_more_pops", pops0 - p, 6);
        chk("gap_delivered", ntx0 - t, 6);
        chk("gap_idle", idle0, 1);
        en = 1'b1;
        drain0(t + 16, "gap_timeout");
        chk("gap_word_count", wc0, 49);

        // Reset after the 5th transfer with data still queued
        t = ntx0;
        for (int i = 0; i < 16; i++) push0(8'h60 + 8'(i));
        for (int k = 0; k < 30 && (ntx0 - t) < 5; k++) tick();
        chk("rst_mid_reached", ntx0 - t, 5);
        rst = 1'b1;
        #1;
        chk("rst_mid_read_enable", re0, 0);
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", ov0, 0);
        chk("rst_mid_data", od0, 0);
        chk("rst_mid_last", ol0, 0);
        chk("rst_mid_word_count", wc0, 0);
        chk("rst_mid_idle", idle0, 1);
        q0.delete();
        eidx = 0;
        rem = fw0 - fr0;
        for (int k = fr0; k < fw0; k++) expect0(fm0[k]);
        t = ntx0;
        drain0(t + rem, "rst_mid_timeout");
        chk("rst_mid_final_count", wc0, rem);

        // Narrow counter wrap with single-beat bursts
        for (int i = 0; i < 20; i++) begin
            fm1[fw1] = 8'hC0 + 8'(i);
            fw1++;
            e.d = 8'hC0 + 8'(i);
            e.l = 1'b1;
            e.wc = 16'(i);
            q1.push_back(e);
        end
        for (int k = 0; k < 60 && !(ntx1 >= 20 && idle1); k++) tick();
        chk("wrap_transfers", ntx1, 20);
        chk("wrap_word_count", wc1, 4);
        chk("wrap_idle", idle1, 1);

        chk("sb0_leftover", q0.size(), 0);
        chk("sb1_leftover", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
